// File: rtl/pwm_precond_pkg.sv
// Shared types for the PWM preconditioner: FSM states, edge pair, split-stage intermediate.
// PWM_PRECOND_PIPE_EN selects two compute register stages instead of one.
package pwm_precond_pkg;

   // Value width that edge_t and raw_t are sized for; the top's WIDTH must match it.
   localparam int EDGE_W = 13;

`ifdef PWM_PRECOND_PIPE_EN
   localparam int PIPE_STAGES = 2;
`else
   localparam int PIPE_STAGES = 1;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} state_t;

   typedef struct packed {
      logic [EDGE_W-1:0] rise;
      logic [EDGE_W-1:0] fall;
   } edge_t;

   // Result of the half-duty/add step, before the modulo-cycle wrap fix.
   typedef struct packed {
      logic                     off;
      logic                     full;
      logic [EDGE_W-1:0]        c;
      logic signed [EDGE_W+1:0] r;
      logic signed [EDGE_W+1:0] f;
   } raw_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// Combinational (cycle, duty, phase) -> rise/fall edge converter, split into add and wrap halves
// so the parent can place a register between them; zero latency, no flow control.
module pwm_edge_calc
   import pwm_precond_pkg::*;
(
   input  logic [EDGE_W-1:0] c,
   input  logic [EDGE_W-1:0] d,
   input  logic [EDGE_W-1:0] p,
   output raw_t              raw,
   input  raw_t              raw_q,
   output edge_t             edges
);

   localparam int IW = EDGE_W + 2;
   localparam logic signed [IW-1:0] ONE = IW'(1);

   logic signed [IW-1:0] c_s, d_s, p_s, p_w;
   logic signed [IW-1:0] cq_s, r_fix, f_fix;
   logic                 unused_bits;

   always_comb begin
      c_s = $signed({2'b00, c});
      d_s = $signed({2'b00, d});
      p_s = $signed({2'b00, p});
      // Out-of-range phase is folded back into the period once.
      p_w = (p_s >= c_s) ? p_s - c_s : p_s;
      raw      = '0;
      raw.off  = (d == '0);
      raw.full = (d_s >= c_s);
      raw.c    = c;
      raw.r    = p_w - (d_s >>> 1);
      raw.f    = p_w + ((d_s + ONE) >>> 1);
   end

   always_comb begin
      cq_s  = $signed({2'b00, raw_q.c});
      r_fix = raw_q.r;
      f_fix = raw_q.f;
      if (r_fix[IW-1])
         r_fix = r_fix + cq_s;
      if (f_fix >= cq_s)
         f_fix = f_fix - cq_s;
      edges = '0;
      if (!raw_q.off) begin
         if (raw_q.full) begin
            edges.fall = raw_q.c;
         end else begin
            edges.rise = r_fix[EDGE_W-1:0];
            edges.fall = f_fix[EDGE_W-1:0];
         end
      end
   end

   assign unused_bits = ^{r_fix[IW-1:EDGE_W], f_fix[IW-1:EDGE_W]};

endmodule

// File: rtl/pwm_preconditioner.sv
// Snapshots duty/phase/cycle, serially converts DEPTH entries to PWM edges, commits all at once; OUT_VALID at
// t+DEPTH+3 (t+DEPTH+4 with PWM_PRECOND_PIPE_EN); no backpressure, IN_VALID while busy coalesces into one rerun.
module pwm_preconditioner
   import pwm_precond_pkg::*;
#(
   parameter int WIDTH = EDGE_W,
   parameter int DEPTH = 249
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [DEPTH-1:0][WIDTH-1:0] cycle,
   input  logic [DEPTH-1:0][WIDTH-1:0] duty,
   input  logic [DEPTH-1:0][WIDTH-1:0] phase,
   output logic [DEPTH-1:0][WIDTH-1:0] rise,
   output logic [DEPTH-1:0][WIDTH-1:0] fall,
   output logic                        out_valid,
   output logic                        busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t                        state, state_nxt;
   logic [IDX_W-1:0]              idx;
   logic                          pending;
   logic                          snap, issue, commit;
   logic [DEPTH-1:0][WIDTH-1:0]   cyc_sh, duty_sh, phase_sh;
   logic [DEPTH-1:0][WIDTH-1:0]   rise_sh, fall_sh;
   raw_t                          raw, raw_q;
   edge_t                         edges, res_q;
   logic [PIPE_STAGES-1:0]        vld_sr;
   logic [PIPE_STAGES-1:0][IDX_W-1:0] idx_sr;

   assign busy = (state != IDLE);

   always_comb begin
      state_nxt = state;
      snap      = 1'b0;
      issue     = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               snap      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            issue = 1'b1;
            if (idx == LAST_IDX)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (vld_sr == '0)
               state_nxt = COMMIT;
         end
         COMMIT: begin
            commit = 1'b1;
            // A pulse landing in this very cycle is honoured without a trip through IDLE.
            if (pending || in_valid) begin
               snap      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         pending   <= 1'b0;
         out_valid <= 1'b0;
         rise      <= '0;
         fall      <= '0;
         vld_sr    <= '0;
      end else begin
         state     <= state_nxt;
         out_valid <= commit;
         vld_sr    <= PIPE_STAGES'({vld_sr, issue});
         if (snap)
            idx <= '0;
         else if (issue)
            idx <= idx + 1'b1;
         if (snap)
            pending <= 1'b0;
         else if (in_valid && busy)
            pending <= 1'b1;
         if (commit) begin
            rise <= rise_sh;
            fall <= fall_sh;
         end
      end
   end

   // Data-path storage needs no reset: the FSM never commits a set it has not fully rewritten.
   always_ff @(posedge clk) begin
      if (snap) begin
         cyc_sh   <= cycle;
         duty_sh  <= duty;
         phase_sh <= phase;
      end
      idx_sr <= (PIPE_STAGES*IDX_W)'({idx_sr, idx});
      res_q  <= edges;
      if (vld_sr[PIPE_STAGES-1]) begin
         rise_sh[idx_sr[PIPE_STAGES-1]] <= res_q.rise;
         fall_sh[idx_sr[PIPE_STAGES-1]] <= res_q.fall;
      end
   end

`ifdef PWM_PRECOND_PIPE_EN
   always_ff @(posedge clk) begin
      raw_q <= raw;
   end
`else
   assign raw_q = raw;
`endif

   pwm_edge_calc u_edge_calc (
      .c     (cyc_sh[idx]),
      .d     (duty_sh[idx]),
      .p     (phase_sh[idx]),
      .raw   (raw),
      .raw_q (raw_q),
      .edges (edges)
   );

endmodule
